// File: rtl/eightbit_mem.sv
// 256 x 8 program/data memory for an 8-bit CPU: optional fill on reset, a byte-stream
// loader, then single-cycle CPU reads/writes once the program is in place.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_CLEAR | writing FILL_BYTE to bytes 0..255, one per cycle
//   ST_LOAD  | accepting loader bytes into consecutive addresses
//   ST_RUN   | CPU owns the memory; left only by rst
module eightbit_mem #(
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [7:0]  FILL_BYTE      = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  addr,
    input  logic [7:0]  wdata,
    input  logic        write_en,
    input  logic        memclk,
    output logic [7:0]  rdata,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        cpu_run,
    output logic [8:0]  load_count,
    output logic        load_err
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  clear_ptr;
    logic [7:0]  load_ptr;
    logic [7:0]  mem [256];

    logic        xfer;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [7:0]  mem_wdata;

    assign xfer = (state == ST_LOAD) && load_valid && load_ready;

    // Single write port shared by the clear sweep, the loader and the CPU.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = wdata;
        if (!rst) begin
            case (state)
                ST_CLEAR: begin
                    mem_we    = 1'b1;
                    mem_waddr = clear_ptr;
                    mem_wdata = FILL_BYTE;
                end
                ST_LOAD: begin
                    mem_we    = xfer;
                    mem_waddr = load_ptr;
                    mem_wdata = load_data;
                end
                ST_RUN: begin
                    mem_we    = memclk && write_en;
                    mem_waddr = addr;
                    mem_wdata = wdata;
                end
                default: mem_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLEAR_ON_RESET)
                state <= ST_CLEAR;
            else
                state <= ST_LOAD;
            clear_ptr  <= 8'h00;
            load_ptr   <= 8'h00;
            load_count <= 9'd0;
            load_err   <= 1'b0;
            rdata      <= 8'h00;
            load_ready <= 1'b0;
            cpu_run    <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clear_ptr <= clear_ptr + 8'd1;
                    if (clear_ptr == 8'hFF) begin
                        state      <= ST_LOAD;
                        load_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    load_ready <= 1'b1;
                    if (xfer) begin
                        if (load_ptr != 8'hFF)
                            load_ptr <= load_ptr + 8'd1;
                        if (load_count != 9'd256)
                            load_count <= load_count + 9'd1;
                        // The final byte slot ends loading even without load_last.
                        if (load_last || load_ptr == 8'hFF) begin
                            state      <= ST_RUN;
                            load_ready <= 1'b0;
                            cpu_run    <= 1'b1;
                            if (!load_last)
                                load_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    load_ready <= 1'b0;
                    cpu_run    <= 1'b1;
                    if (memclk)
                        rdata <= mem[addr];
                end
                default: begin
                    state      <= ST_LOAD;
                    load_ready <= 1'b0;
                    cpu_run    <= 1'b0;
                    rdata      <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eightbit_mem.sv
// Self-checking bench for eightbit_mem: directed vector table plus randomized loading
// and CPU traffic, all compared against a simple array-based reference model.
module tb_eightbit_mem;

    localparam logic [7:0] FILL = 8'hC3;
    localparam int P_CLEAR = 0;
    localparam int P_LOAD  = 1;
    localparam int P_RUN   = 2;

    logic        clk = 1'b0;
    logic        rst, write_en, memclk, load_valid, load_last;
    logic [7:0]  addr, wdata, load_data, rdata;
    logic        load_ready, cpu_run, load_err;
    logic [8:0]  load_count;

    always #5 clk = ~clk;

    eightbit_mem #(.CLEAR_ON_RESET(1'b1), .FILL_BYTE(FILL)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .write_en(write_en),
        .memclk(memclk), .rdata(rdata), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .cpu_run(cpu_run),
        .load_count(load_count), .load_err(load_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase, bytes loaded, overflow flag, read register, memory image.
    int          m_phase, m_clr, m_cnt;
    bit          m_err;
    logic [7:0]  m_rd;
    logic [7:0]  m_mem [256];

    task automatic model_update();
        if (rst) begin
            m_phase = P_CLEAR; m_clr = 0; m_cnt = 0; m_err = 0; m_rd = 8'h00;
        end else if (m_phase == P_CLEAR) begin
            m_mem[m_clr] = FILL;
            m_clr++;
            if (m_clr == 256) m_phase = P_LOAD;
        end else if (m_phase == P_LOAD) begin
            if (load_valid) begin
                m_mem[m_cnt] = load_data;
                m_cnt++;
                if (load_last) m_phase = P_RUN;
                else if (m_cnt == 256) begin
                    m_err = 1;
                    m_phase = P_RUN;
                end
            end
        end else if (memclk) begin
            m_rd = m_mem[addr];
            if (write_en) m_mem[addr] = wdata;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("model {ready,run,err,count,rdata}",
              {load_ready, cpu_run, load_err, load_count, rdata},
              {m_phase == P_LOAD, m_phase == P_RUN, m_err, 9'(m_cnt), m_rd});
    endtask

    task automatic idle();
        load_valid = 0; load_data = 8'h00; load_last = 0;
        memclk = 0; write_en = 0; addr = 8'h00; wdata = 8'h00;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic wait_clear();
        repeat (256) step();
    endtask

    task automatic cpu_read(input logic [7:0] a, input logic [7:0] exp, input string name);
        idle();
        memclk = 1; addr = a;
        step();
        check(name, rdata, exp);
        memclk = 0;
    endtask

    typedef struct {
        logic        lv; logic [7:0] ld; logic ll;
        logic        mc; logic we; logic [7:0] a; logic [7:0] wd;
        logic [8:0]  e_cnt; logic e_run; logic e_rdy; logic [7:0] e_rd;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [7:0] first_byte;
        rst = 0;
        idle();

        tbl[0]  = '{1, 8'h01, 0, 1, 1, 8'h41, 8'h77, 9'd1, 0, 1, 8'h00};
        tbl[1]  = '{1, 8'h2A, 0, 1, 1, 8'h41, 8'h77, 9'd2, 0, 1, 8'h00};
        tbl[2]  = '{1, 8'h03, 1, 1, 1, 8'h41, 8'h77, 9'd3, 1, 0, 8'h00};
        tbl[3]  = '{0, 8'h00, 0, 1, 0, 8'h01, 8'h00, 9'd3, 1, 0, 8'h2A};
        tbl[4]  = '{0, 8'h00, 0, 1, 1, 8'h40, 8'h5C, 9'd3, 1, 0, FILL};
        tbl[5]  = '{0, 8'h00, 0, 1, 0, 8'h40, 8'h00, 9'd3, 1, 0, 8'h5C};
        tbl[6]  = '{0, 8'h00, 0, 0, 1, 8'h40, 8'h99, 9'd3, 1, 0, 8'h5C};
        tbl[7]  = '{0, 8'h00, 0, 1, 0, 8'h40, 8'h00, 9'd3, 1, 0, 8'h5C};
        tbl[8]  = '{0, 8'h00, 0, 1, 0, 8'h02, 8'h00, 9'd3, 1, 0, 8'h03};
        tbl[9]  = '{1, 8'hAA, 1, 1, 0, 8'h00, 8'h00, 9'd3, 1, 0, 8'h01};
        tbl[10] = '{0, 8'h00, 0, 1, 1, 8'h02, 8'hEE, 9'd3, 1, 0, 8'h03};
        tbl[11] = '{0, 8'h00, 0, 1, 0, 8'h02, 8'h00, 9'd3, 1, 0, 8'hEE};
        tbl[12] = '{0, 8'h00, 0, 1, 0, 8'h41, 8'h00, 9'd3, 1, 0, FILL};

        // Clear timing with load_valid held high throughout.
        do_reset();
        check("reset_outputs", {load_ready, cpu_run, load_err, load_count, rdata}, 32'd0);
        load_valid = 1; load_data = 8'h11;
        for (int i = 0; i < 256; i++) begin
            step();
            check($sformatf("clear_ready_c%0d", i + 1), load_ready, (i == 255) ? 32'd1 : 32'd0);
        end
        step();
        check("first_xfer_count", load_count, 32'd1);
        load_data = 8'h22; load_last = 1;
        step();
        check("run_after_last", {cpu_run, load_ready, load_count}, {2'b10, 9'd2});
        cpu_read(8'h80, FILL, "unloaded_reads_fill");
        cpu_read(8'h00, 8'h11, "byte0_after_clear_wait");

        // Directed vector table: load three bytes, then CPU read/write corner cases.
        do_reset();
        check("reset_from_run_rdata", rdata, 32'd0);
        wait_clear();
        for (int i = 0; i < 13; i++) begin
            load_valid = tbl[i].lv; load_data = tbl[i].ld; load_last = tbl[i].ll;
            memclk = tbl[i].mc; write_en = tbl[i].we; addr = tbl[i].a; wdata = tbl[i].wd;
            step();
            check($sformatf("vec%0d", i), {load_count, cpu_run, load_ready, rdata},
                  {tbl[i].e_cnt, tbl[i].e_run, tbl[i].e_rdy, tbl[i].e_rd});
        end

        // Overflow: 256 bytes without load_last.
        do_reset();
        wait_clear();
        first_byte = 8'(($urandom % 255) + 1);
        for (int i = 0; i < 256; i++) begin
            load_valid = 1;
            load_data = (i == 0) ? first_byte : 8'($urandom);
            step();
        end
        check("overflow_flags", {load_err, load_count, cpu_run, load_ready}, {1'b1, 9'd256, 2'b10});
        load_data = 8'h5A;
        step();
        check("overflow_count_sat", load_count, 32'd256);
        cpu_read(8'h00, first_byte, "overflow_no_wrap_byte0");

        // Reset mid-load (with a simultaneous transfer), then a short reload.
        do_reset();
        wait_clear();
        for (int i = 0; i < 5; i++) begin
            load_valid = 1; load_data = 8'h50 + 8'(i);
            step();
        end
        load_data = 8'h66;
        rst = 1;
        step();
        rst = 0;
        check("mid_load_reset", {load_count, load_err, load_ready}, 32'd0);
        idle();
        wait_clear();
        load_valid = 1; load_data = 8'hA0;
        step();
        load_data = 8'hA1; load_last = 1;
        step();
        check("reload_count", {load_count, load_err, cpu_run}, {9'd2, 2'b01});
        cpu_read(8'h01, 8'hA1, "reload_byte1");
        for (int i = 2; i < 5; i++)
            cpu_read(8'(i), FILL, $sformatf("stale_byte%0d_filled", i));

        // Random loader gaps and stray load_last, then random CPU traffic.
        do_reset();
        wait_clear();
        for (int k = 0; k < 2000 && !cpu_run; k++) begin
            load_valid = 1'($urandom_range(0, 1));
            load_data  = 8'($urandom);
            load_last  = load_valid ? (m_cnt >= 20 && $urandom_range(0, 7) == 0)
                                    : 1'($urandom_range(0, 1));
            step();
        end
        check("random_load_finished", cpu_run, 32'd1);
        for (int k = 0; k < 300; k++) begin
            idle();
            memclk   = 1'($urandom_range(0, 1));
            write_en = 1'($urandom_range(0, 1));
            addr     = 8'($urandom_range(0, 63));
            wdata    = 8'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
